rtc_calendar_counter: RTL

// Timekeeping stage feeding the display multiplexer: counts seconds, minutes, hours (24 h),
// day-of-month, month and day-of-week from a prescaled tick. Presents BCD digits for the

---
 rtl/rtc_calendar_counter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_calendar_counter.sv
// Real-time clock/calendar: prescaled tick -> sec/min/hour/day/month/dow with BCD and binary views.
// Field loads take priority over a coincident second advance; all outputs are registered.
module rtc_calendar_counter #(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned RESET_DOW = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Enable,
  input  logic       SetStrobe,
  input  logic [2:0] SetField,
  input  logic [6:0] SetValue,
  output logic       SetError,
  output logic [3:0] SecOnes,
  output logic [3:0] SecTens,
  output logic [3:0] MinOnes,
  output logic [3:0] MinTens,
  output logic [3:0] HourOnes,
  output logic [3:0] HourTens,
  output logic [3:0] DayOnes,
  output logic [3:0] DayTens,
  output logic [3:0] MonOnes,
  output logic [3:0] MonTens,
  output logic [5:0] SecBin,
  output logic [5:0] MinBin,
  output logic [4:0] HourBin,
  output logic [4:0] DayBin,
  output logic [3:0] MonBin,
  output logic [2:0] DowBin,
  output logic       SecPulse,
  output logic       MinPulse,
  output logic       DayPulse
);

  localparam logic [2:0] FLD_SEC  = 3'd0;
  localparam logic [2:0] FLD_MIN  = 3'd1;
  localparam logic [2:0] FLD_HOUR = 3'd2;
  localparam logic [2:0] FLD_DAY  = 3'd3;
  localparam logic [2:0] FLD_MON  = 3'd4;
  localparam logic [2:0] FLD_DOW  = 3'd5;
  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);
  localparam int NUM_BCD = 5;

  function automatic logic [4:0] month_len(input logic [3:0] m);
    case (m)
      4'd2:                      month_len = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
  endfunction

  // Values never exceed 59, so six conditional subtractions cover every tens digit.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] tens;
    r    = v;
    tens = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 7'd10) begin
        r    = r - 7'd10;
        tens = tens + 4'd1;
      end
    end
    to_bcd = {tens, r[3:0]};
  endfunction

  logic [7:0] presc_reg, presc_next;
  logic [5:0] sec_reg, sec_next;
  logic [5:0] min_reg, min_next;
  logic [4:0] hour_reg, hour_next;
  logic [4:0] day_reg, day_next;
  logic [3:0] mon_reg, mon_next;
  logic [2:0] dow_reg, dow_next;
  logic       sec_pulse_reg, sec_pulse_next;
  logic       min_pulse_reg, min_pulse_next;
  logic       day_pulse_reg, day_pulse_next;
  logic       set_error_reg, set_error_next;
  logic       load_ok, load, wrap, advance;
  logic [4:0] new_mon_len;

  always_comb begin
    presc_next     = presc_reg;
    sec_next       = sec_reg;
    min_next       = min_reg;
    hour_next      = hour_reg;
    day_next       = day_reg;
    mon_next       = mon_reg;
    dow_next       = dow_reg;
    sec_pulse_next = 1'b0;
    min_pulse_next = 1'b0;
    day_pulse_next = 1'b0;
    new_mon_len    = month_len(SetValue[3:0]);

    case (SetField)
      FLD_SEC, FLD_MIN: load_ok = (SetValue <= 7'd59);
      FLD_HOUR:         load_ok = (SetValue <= 7'd23);
      FLD_DAY:          load_ok = (SetValue >= 7'd1) && (SetValue <= {2'b00, month_len(mon_reg)});
      FLD_MON:          load_ok = (SetValue >= 7'd1) && (SetValue <= 7'd12);
      FLD_DOW:          load_ok = (SetValue <= 7'd6);
      default:          load_ok = 1'b0;
    endcase

    load           = SetStrobe & load_ok;
    set_error_next = SetStrobe & ~load_ok;
    wrap           = Tick & Enable & (presc_reg == PRESC_MAX);
    advance        = wrap & ~load;

    if (Tick && Enable) begin
      presc_next = wrap ? 8'd0 : presc_reg + 8'd1;
    end

    // Full carry chain resolves within the one advancing edge.
    if (advance) begin
      sec_pulse_next = 1'b1;
      if (sec_reg == 6'd59) begin
        sec_next       = 6'd0;
        min_pulse_next = 1'b1;
        if (min_reg == 6'd59) begin
          min_next = 6'd0;
          if (hour_reg == 5'd23) begin
            hour_next      = 5'd0;
            day_pulse_next = 1'b1;
            dow_next       = (dow_reg == 3'd6) ? 3'd0 : dow_reg + 3'd1;
            if (day_reg == month_len(mon_reg)) begin
              day_next = 5'd1;
              mon_next = (mon_reg == 4'd12) ? 4'd1 : mon_reg + 4'd1;
            end else begin
              day_next = day_reg + 5'd1;
            end
          end else begin
            hour_next = hour_reg + 5'd1;
          end
        end else begin
          min_next = min_reg + 6'd1;
        end
      end else begin
        sec_next = sec_reg + 6'd1;
      end
    end

    if (load) begin
      case (SetField)
        FLD_SEC: begin
          sec_next   = SetValue[5:0];
          presc_next = 8'd0;
        end
        FLD_MIN:  min_next  = SetValue[5:0];
        FLD_HOUR: hour_next = SetValue[4:0];
        FLD_DAY:  day_next  = SetValue[4:0];
        FLD_MON: begin
          mon_next = SetValue[3:0];
          if (day_reg > new_mon_len) begin
            day_next = new_mon_len;
          end
        end
        FLD_DOW:  dow_next  = SetValue[2:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      presc_reg     <= 8'd0;
      sec_reg       <= 6'd0;
      min_reg       <= 6'd0;
      hour_reg      <= 5'd0;
      day_reg       <= 5'd1;
      mon_reg       <= 4'd1;
      dow_reg       <= 3'(RESET_DOW);
      sec_pulse_reg <= 1'b0;
      min_pulse_reg <= 1'b0;
      day_pulse_reg <= 1'b0;
      set_error_reg <= 1'b0;
    end else begin
      presc_reg     <= presc_next;
      sec_reg       <= sec_next;
      min_reg       <= min_next;
      hour_reg      <= hour_next;
      day_reg       <= day_next;
      mon_reg       <= mon_next;
      dow_reg       <= dow_next;
      sec_pulse_reg <= sec_pulse_next;
      min_pulse_reg <= min_pulse_next;
      day_pulse_reg <= day_pulse_next;
      set_error_reg <= set_error_next;
    end
  end

  // BCD registers load from the same next-state values as the binary registers, so both agree every cycle.
  logic [6:0] bcd_src [NUM_BCD];
  logic [7:0] bcd_reg [NUM_BCD];

  assign bcd_src[0] = {1'b0, sec_next};
  assign bcd_src[1] = {1'b0, min_next};
  assign bcd_src[2] = {2'b00, hour_next};
  assign bcd_src[3] = {2'b00, day_next};
  assign bcd_src[4] = {3'b000, mon_next};

  generate
    for (genvar gi = 0; gi < NUM_BCD; gi++) begin : g_bcd
      localparam logic [7:0] BCD_RST = (gi >= 3) ? 8'h01 : 8'h00;
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          bcd_reg[gi] <= BCD_RST;
        end else begin
          bcd_reg[gi] <= to_bcd(bcd_src[gi]);
        end
      end
    end
  endgenerate

  assign SecOnes  = bcd_reg[0][3:0];
  assign SecTens  = bcd_reg[0][7:4];
  assign MinOnes  = bcd_reg[1][3:0];
  assign MinTens  = bcd_reg[1][7:4];
  assign HourOnes = bcd_reg[2][3:0];
  assign HourTens = bcd_reg[2][7:4];
  assign DayOnes  = bcd_reg[3][3:0];
  assign DayTens  = bcd_reg[3][7:4];
  assign MonOnes  = bcd_reg[4][3:0];
  assign MonTens  = bcd_reg[4][7:4];

  assign SecBin   = sec_reg;
  assign MinBin   = min_reg;
  assign HourBin  = hour_reg;
  assign DayBin   = day_reg;
  assign MonBin   = mon_reg;
  assign DowBin   = dow_reg;
  assign SecPulse = sec_pulse_reg;
  assign MinPulse = min_pulse_reg;
  assign DayPulse = day_pulse_reg;
  assign SetError = set_error_reg;

endmodule
